// File: rtl/wishbone_pkg.sv
// wishbone_pkg: 32-bit Wishbone command bus types shared by the I/O bridge and its devices,
// plus the fault constants and state encoding of the I/O bus watchdog.
package wishbone_pkg;

  localparam int unsigned WB_TID_W = 8;

  typedef enum logic [1:0] {
    OKAY = 2'd0,
    ERR  = 2'd1,
    IRQ  = 2'd2
  } wb_err_t;

  typedef struct packed {
    logic                cyc;
    logic                stb;
    logic                we;
    logic [3:0]          sel;
    logic [31:0]         adr;
    logic [31:0]         dat;
    logic [WB_TID_W-1:0] tid;
  } wb_cmd_request32_t;

  typedef struct packed {
    logic                ack;
    wb_err_t             err;
    logic                rty;
    logic                next;
    logic                stall;
    logic [3:0]          pri;
    logic [WB_TID_W-1:0] tid;
    logic [31:0]         dat;
  } wb_cmd_response32_t;

  localparam logic [31:0] WB_IOWDOG_FAULT_DAT = 32'hDEADBEEF;
  localparam logic [3:0]  WB_IOWDOG_FAULT_PRI = 4'd8;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    FAULT,
    HOLD,
    WAIT
  } wb_iowdog_state_t;

endpackage

// File: rtl/wb_io_bus_watchdog32.sv
// wb_io_bus_watchdog32: terminates I/O bus cycles that no device acks within TIMEOUT clocks
// with an ERR response. Define WB_IOWDOG_CNT_EN to add the saturating fault_cnt_o counter.
module wb_io_bus_watchdog32
  import wishbone_pkg::*;
#(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned CW       = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  wb_cmd_request32_t   req_i,
  input  wb_cmd_response32_t  dev_resp_i [CHANNELS],
  output wb_cmd_response32_t  resp_o,
  output logic                fault_o,
  output logic [31:0]         fault_adr_o,
  output logic [WB_TID_W-1:0] fault_tid_o
`ifdef WB_IOWDOG_CNT_EN
  ,
  output logic [15:0]         fault_cnt_o
`endif
);

  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  wb_iowdog_state_t    state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [WB_TID_W-1:0] tid_q, tid_d;
  logic                dev_ack;
  logic                tid_changed;
  wb_cmd_response32_t  fault_resp;
  logic                unused_dev;
  logic                unused_req;

  assign unused_req  = ^{req_i.stb, req_i.we, req_i.sel, req_i.dat};
  assign tid_changed = req_i.cyc && (req_i.tid != tid_q);

  // IRQ/MSI acks travel through a separate bridge queue and never complete a cycle
  always_comb begin
    dev_ack    = 1'b0;
    unused_dev = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (dev_resp_i[i].ack && (dev_resp_i[i].err != IRQ)) dev_ack = 1'b1;
      unused_dev = unused_dev ^ (^{dev_resp_i[i]});
    end
  end

  always_comb begin
    fault_resp     = '0;
    fault_resp.ack = 1'b1;
    fault_resp.err = ERR;
    fault_resp.dat = WB_IOWDOG_FAULT_DAT;
    fault_resp.tid = tid_q;
    fault_resp.pri = WB_IOWDOG_FAULT_PRI;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tid_d   = tid_q;
    unique case (state_q)
      IDLE: begin
        if (req_i.cyc) begin
          state_d = COUNT;
          cnt_d   = CNT_ONE;
          tid_d   = req_i.tid;
        end
      end
      COUNT: begin
        // a device ack on the final count wins over the timeout
        if (dev_ack) begin
          state_d = WAIT;
        end else if (!req_i.cyc) begin
          state_d = IDLE;
        end else if (tid_changed) begin
          cnt_d = CNT_ONE;
          tid_d = req_i.tid;
        end else if (cnt_q == TIMEOUT_C) begin
          state_d = FAULT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      FAULT: state_d = HOLD;
      HOLD: begin
        if (!req_i.cyc) state_d = IDLE;
      end
      WAIT: begin
        if (!req_i.cyc) begin
          state_d = IDLE;
        end else if (tid_changed) begin
          state_d = COUNT;
          cnt_d   = CNT_ONE;
          tid_d   = req_i.tid;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // outputs are registered from the next state so the ack lands TIMEOUT+1 clocks after cyc
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tid_q       <= '0;
      resp_o      <= '0;
      fault_o     <= 1'b0;
      fault_adr_o <= '0;
      fault_tid_o <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tid_q   <= tid_d;
      fault_o <= (state_d == FAULT);
      if (state_d == FAULT) begin
        resp_o      <= fault_resp;
        fault_adr_o <= req_i.adr;
        fault_tid_o <= tid_q;
      end else if (state_d != HOLD) begin
        resp_o <= '0;
      end
    end
  end

`ifdef WB_IOWDOG_CNT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fault_cnt_o <= '0;
    end else if ((state_d == FAULT) && (fault_cnt_o != '1)) begin
      fault_cnt_o <= fault_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_io_bus_watchdog32.sv
// tb_wb_io_bus_watchdog32: directed scenarios plus randomized traffic checked against a
// transaction-level model of the watchdog (TIMEOUT=8).
module tb_wb_io_bus_watchdog32;
  import wishbone_pkg::*;

  localparam int unsigned TO = 8;

  logic               clk   = 1'b0;
  logic               rst_n = 1'b1;
  wb_cmd_request32_t  req;
  wb_cmd_response32_t dev_resp [2];
  wb_cmd_response32_t resp;
  logic               fault;
  logic [31:0]        fault_adr;
  logic [7:0]         fault_tid;
`ifdef WB_IOWDOG_CNT_EN
  logic [15:0]        fault_cnt;
`endif

  always #5 clk = ~clk;

  wb_io_bus_watchdog32 #(
    .CHANNELS(2),
    .TIMEOUT (TO),
    .CW      (16)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_i      (req),
    .dev_resp_i (dev_resp),
    .resp_o     (resp),
    .fault_o    (fault),
    .fault_adr_o(fault_adr),
    .fault_tid_o(fault_tid)
`ifdef WB_IOWDOG_CNT_EN
    ,
    .fault_cnt_o(fault_cnt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: tracks the age of the unanswered transaction and any pending error reply.
  int          m_age;      // clocks the current transaction has gone unanswered, 0 = none
  bit          m_served;   // a device answered the current transaction
  bit          m_err;      // error reply on the bus
  bit          m_fresh;    // error reply issued on the most recent clock
  bit          m_pulse;
  logic [7:0]  m_tid;
  logic [31:0] m_fadr;
  logic [7:0]  m_ftid;
  int          m_fcnt;

  function automatic void model_reset();
    m_age = 0; m_served = 0; m_err = 0; m_fresh = 0; m_pulse = 0;
    m_tid = '0; m_fadr = '0; m_ftid = '0; m_fcnt = 0;
  endfunction

  function automatic void model_edge(input bit cyc, input logic [7:0] tid,
                                     input logic [31:0] adr, input bit acked);
    m_pulse = 0;
    if (m_err) begin
      if (!m_fresh && !cyc) m_err = 0;
      m_fresh = 0;
    end else if (m_age == 0) begin
      if (m_served) begin
        if (!cyc) m_served = 0;
        else if (tid != m_tid) begin m_served = 0; m_age = 1; m_tid = tid; end
      end else if (cyc) begin
        m_age = 1; m_tid = tid;
      end
    end else begin
      if (acked) begin
        m_age = 0; m_served = 1;
      end else if (!cyc) begin
        m_age = 0;
      end else if (tid != m_tid) begin
        m_age = 1; m_tid = tid;
      end else if (m_age == int'(TO)) begin
        m_age = 0; m_err = 1; m_fresh = 1; m_pulse = 1;
        m_fadr = adr; m_ftid = m_tid;
        if (m_fcnt < 65535) m_fcnt++;
      end else begin
        m_age++;
      end
    end
  endfunction

  function automatic logic [63:0] pk(input wb_cmd_response32_t r);
    logic [63:0] v;
    v = '0;
    v[$bits(wb_cmd_response32_t)-1:0] = r;
    return v;
  endfunction

  function automatic wb_cmd_response32_t model_resp();
    wb_cmd_response32_t r;
    r = '0;
    if (m_err) begin
      r.ack = 1'b1; r.err = ERR; r.dat = 32'hDEADBEEF; r.tid = m_ftid; r.pri = 4'd8;
    end
    return r;
  endfunction

  task automatic compare_all();
    check_eq("resp", pk(resp), pk(model_resp()));
    check_eq("fault", 64'(fault), 64'(m_pulse));
    check_eq("fault_adr", 64'(fault_adr), 64'(m_fadr));
    check_eq("fault_tid", 64'(fault_tid), 64'(m_ftid));
`ifdef WB_IOWDOG_CNT_EN
    check_eq("fault_cnt", 64'(fault_cnt), 64'(m_fcnt));
`endif
  endtask

  task automatic tick();
    bit acked;
    @(posedge clk);
    acked = 0;
    for (int i = 0; i < 2; i++)
      if (dev_resp[i].ack && dev_resp[i].err != IRQ) acked = 1;
    model_edge(req.cyc, req.tid, req.adr, acked);
    #1;
    compare_all();
  endtask

  task automatic dev_idle();
    dev_resp[0] = '0;
    dev_resp[1] = '0;
  endtask

  task automatic set_req(input bit cyc, input logic [31:0] adr, input logic [7:0] tid);
    req     = '0;
    req.cyc = cyc;
    req.stb = cyc;
    req.sel = 4'hF;
    req.adr = adr;
    req.tid = tid;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bit saw_ack, saw_fault;
    set_req(0, '0, '0);
    dev_idle();
    model_reset();
    #1;
    do_reset();

    // Reset mid-cycle on the fault clock drops outputs immediately
    set_req(1, 32'h0000_2000, 8'd7);
    repeat (TO + 1) tick();
    check_eq("t1_fault_pre_rst", 64'(fault), 64'(1));
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("t1_rst_ack", 64'(resp.ack), 64'(0));
    check_eq("t1_rst_fault", 64'(fault), 64'(0));
    check_eq("t1_rst_adr", 64'(fault_adr), 64'(0));
    set_req(0, '0, '0);
    #1;
    rst_n = 1'b1;
    tick();

    // Unmapped access: fault on the 9th clock after cyc, held until cyc drops
    set_req(1, 32'hFEED_0040, 8'd5);
    repeat (TO) tick();
    check_eq("t3_ack_early", 64'(resp.ack), 64'(0));
    tick();
    check_eq("t3_ack", 64'(resp.ack), 64'(1));
    check_eq("t3_err", 64'(resp.err), 64'(ERR));
    check_eq("t3_dat", 64'(resp.dat), 64'(32'hDEADBEEF));
    check_eq("t3_tid", 64'(resp.tid), 64'(5));
    check_eq("t3_pri", 64'(resp.pri), 64'(8));
    check_eq("t3_fault", 64'(fault), 64'(1));
    check_eq("t3_fadr", 64'(fault_adr), 64'(32'hFEED_0040));
    check_eq("t3_ftid", 64'(fault_tid), 64'(5));
    repeat (3) tick();
    check_eq("t3_hold_ack", 64'(resp.ack), 64'(1));
    check_eq("t3_hold_fault", 64'(fault), 64'(0));
    req.cyc = 1'b0;
    tick();
    check_eq("t3_clear_ack", 64'(resp.ack), 64'(0));
    check_eq("t3_fadr_kept", 64'(fault_adr), 64'(32'hFEED_0040));
    tick();

    // Mapped access: device acks on clock 3
    set_req(1, 32'h0000_1000, 8'd1);
    repeat (2) tick();
    dev_resp[0].ack = 1'b1;
    tick();
    dev_idle();
    saw_ack = 0; saw_fault = 0;
    repeat (12) begin
      tick();
      saw_ack   |= resp.ack;
      saw_fault |= fault;
    end
    check_eq("t2_no_ack", 64'(saw_ack), 64'(0));
    check_eq("t2_no_fault", 64'(saw_fault), 64'(0));
    req.cyc = 1'b0;
    tick();

    // Device ack exactly on the timeout clock
    set_req(1, 32'h0000_3000, 8'd9);
    repeat (TO) tick();
    dev_resp[1].ack = 1'b1;
    tick();
    check_eq("t4_ack_race_fault", 64'(fault), 64'(0));
    dev_idle();
    repeat (3) tick();
    check_eq("t4_ack_race_resp", 64'(resp.ack), 64'(0));
    req.cyc = 1'b0;
    tick();

    // cyc drop exactly on the timeout clock
    set_req(1, 32'h0000_3004, 8'd10);
    repeat (TO) tick();
    req.cyc = 1'b0;
    tick();
    check_eq("t4_drop_race_fault", 64'(fault), 64'(0));
    tick();
    check_eq("t4_drop_race_resp", 64'(resp.ack), 64'(0));

    // IRQ acks do not complete the cycle
    set_req(1, 32'h0000_4000, 8'd11);
    repeat (3) tick();
    dev_resp[1].ack = 1'b1;
    dev_resp[1].err = IRQ;
    tick();
    dev_idle();
    repeat (TO - 4) tick();
    check_eq("t5_ack_early", 64'(resp.ack), 64'(0));
    tick();
    check_eq("t5_fault", 64'(fault), 64'(1));
    check_eq("t5_ack", 64'(resp.ack), 64'(1));
    req.cyc = 1'b0;
    repeat (2) tick();

    // Back-to-back tids with cyc held: tid 3 served, tid 4 unmapped
    do_reset();
    set_req(1, 32'h0000_5000, 8'd3);
    tick();
    dev_resp[0].ack = 1'b1;
    tick();
    dev_idle();
    repeat (3) tick();
    req.tid = 8'd4;
    req.adr = 32'h0000_BAD0;
    repeat (TO) tick();
    check_eq("t6_fault_early", 64'(fault), 64'(0));
    tick();
    check_eq("t6_fault", 64'(fault), 64'(1));
    check_eq("t6_resp_tid", 64'(resp.tid), 64'(4));
    check_eq("t6_ftid", 64'(fault_tid), 64'(4));
    check_eq("t6_fadr", 64'(fault_adr), 64'(32'h0000_BAD0));
`ifdef WB_IOWDOG_CNT_EN
    check_eq("t6_fcnt", 64'(fault_cnt), 64'(1));
`endif
    req.cyc = 1'b0;
    repeat (2) tick();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if (req.cyc) begin
        if ($urandom_range(0, 24) == 0) req.cyc = 1'b0;
        else if ($urandom_range(0, 30) == 0) req.tid = 8'($urandom);
      end else if ($urandom_range(0, 3) == 0) begin
        set_req(1, $urandom, 8'($urandom));
      end
      for (int ch = 0; ch < 2; ch++) begin
        dev_resp[ch].ack = ($urandom_range(0, 19) == 0);
        dev_resp[ch].err = ($urandom_range(0, 2) == 0) ? IRQ : OKAY;
        dev_resp[ch].dat = $urandom;
        dev_resp[ch].tid = 8'($urandom);
      end
      if ($urandom_range(0, 499) == 0) do_reset();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
